// File: rtl/ripple_borrow_sub_serial.sv
// Bit-serial ripple-borrow subtractor: computes a - b - bin one bit per clock, LSB first,
// and publishes diff/bout/ovf together with a one-cycle done pulse.
module ripple_borrow_sub_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] sub_bit(input logic ai, input logic bi, input logic bri);
        sub_bit = {(~ai & bi) | (~(ai ^ bi) & bri), ai ^ bi ^ bri};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             armed_q, armed_d;
    logic [1:0]       step_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        idx_d   = idx_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        // The first edge after reset release only arms the block, so a start
        // coincident with that edge is dropped.
        armed_d = 1'b1;
        step_s  = sub_bit(a_sh_q[idx_q], b_sh_q[idx_q], br_q);

        case (state_q)
            IDLE: begin
                if (start && armed_q) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    idx_d   = {IDX_W{1'b0}};
                    res_d   = {WIDTH{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d[idx_q] = step_s[0];
                br_d         = step_s[1];
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    diff_d  = res_d;
                    bout_d  = step_s[1];
                    ovf_d   = (a_sh_q[WIDTH-1] ^ b_sh_q[WIDTH-1]) & (step_s[0] ^ a_sh_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= {WIDTH{1'b0}};
            b_sh_q  <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            br_q    <= 1'b0;
            diff_q  <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            armed_q <= armed_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ripple_borrow_sub_serial.sv
// Scoreboard bench for ripple_borrow_sub_serial (WIDTH=4): the driver queues expected
// {diff,bout,ovf}; a monitor pops and compares on every done pulse and services probes.
module tb_ripple_borrow_sub_serial;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         bin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] diff;
    logic         bout, ovf, busy, done;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W+1:0] exp_q[$];

    int           probe_seq = 0;
    int           probe_ack = 0;
    int           probe_kind = 0;
    logic [31:0]  probe_exp = '0;

    ripple_borrow_sub_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Monitor: sole owner of the comparison counters.
    initial begin : monitor
        logic [W+1:0] e;
        logic [31:0]  act;
        forever begin
            @(negedge clk);
            if (probe_seq != probe_ack) begin
                probe_ack = probe_seq;
                n_vec++;
                if (probe_kind == 0) act = 32'({diff, bout, ovf, busy, done});
                else act = 32'(exp_q.size());
                if (act !== probe_exp) begin
                    n_err++;
                    $display("FAIL probe%0d: got %b, expected %b", probe_kind, act[7:0], probe_exp[7:0]);
                end
            end
            if (!rst && done) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 diff=%b, expected no done", diff);
                end else begin
                    e = exp_q.pop_front();
                    if ({diff, bout, ovf} !== e) begin
                        n_err++;
                        $display("FAIL result: got diff=%b bout=%b ovf=%b, expected diff=%b bout=%b ovf=%b",
                                 diff, bout, ovf, e[W+1:2], e[1], e[0]);
                    end
                end
            end
        end
    end

    task automatic probe(input int kind, input logic [31:0] e);
        probe_kind = kind;
        probe_exp  = e;
        probe_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            $display("FAIL idle_timeout: got busy=1 after 40 cycles, expected 0");
            $fatal(1, "busy stuck");
        end
    endtask

    task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                         input logic [W+1:0] e);
        wait_idle();
        a     = ai;
        b     = bi;
        bin   = ci;
        start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W+1:0] e;
    } vec_t;

    vec_t vecs[8];

    initial begin : driver
        logic [W:0]   s;
        logic [W-1:0] av, bv;
        logic         cv;

        // {a, b, bin, {diff, bout, ovf}} computed by hand
        vecs[0] = '{4'b1001, 4'b0011, 1'b0, {4'b0110, 1'b0, 1'b1}};
        vecs[1] = '{4'b0011, 4'b1001, 1'b0, {4'b1010, 1'b1, 1'b1}};
        vecs[2] = '{4'b1000, 4'b0001, 1'b0, {4'b0111, 1'b0, 1'b1}};
        vecs[3] = '{4'b0000, 4'b0000, 1'b1, {4'b1111, 1'b1, 1'b0}};
        vecs[4] = '{4'b1010, 4'b1010, 1'b0, {4'b0000, 1'b0, 1'b0}};
        vecs[5] = '{4'b0000, 4'b0001, 1'b0, {4'b1111, 1'b1, 1'b0}};
        vecs[6] = '{4'b1111, 4'b1111, 1'b1, {4'b1111, 1'b1, 1'b0}};
        vecs[7] = '{4'b0111, 4'b0111, 1'b1, {4'b1111, 1'b1, 1'b0}};

        @(posedge clk);
        #1;
        probe(0, 32'(8'b0000_0000));
        rst = 1'b0;

        for (int i = 0; i < 8; i++) issue(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].e);

        // Start while busy is ignored; diff keeps the previous result mid-run.
        wait_idle();
        a = 4'b0101; b = 4'b0010; bin = 1'b0; start = 1'b1;
        exp_q.push_back({4'b0011, 1'b0, 1'b0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 4'b1111;
        @(posedge clk);
        #1;
        probe(0, 32'({4'b1111, 1'b1, 1'b0, 1'b1, 1'b0}));
        start = 1'b0; a = 4'b0000;

        // Continuous start: two operations with one idle cycle between them.
        wait_idle();
        a = 4'b0110; b = 4'b0011; bin = 1'b0; start = 1'b1;
        exp_q.push_back({4'b0011, 1'b0, 1'b0});
        exp_q.push_back({4'b0011, 1'b0, 1'b0});
        repeat (5) @(negedge clk);
        probe(0, 32'({4'b0011, 1'b0, 1'b0, 1'b0, 1'b0}));
        repeat (2) @(negedge clk);
        start = 1'b0;

        // Reset pulse between E2 and E3 aborts the operation with no done.
        wait_idle();
        a = 4'b0101; b = 4'b0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        probe(0, 32'(8'b0000_0000));
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(4'b0111, 4'b0001, 1'b0, {4'b0110, 1'b0, 1'b0});

        // Sweep against an adder model: a + ~b + ~bin, bout = ~carry.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    av = W'(ai);
                    bv = W'(bi);
                    cv = (ci != 0);
                    s  = {1'b0, av} + {1'b0, ~bv} + {4'b0000, ~cv};
                    issue(av, bv, cv, {s[W-1:0], ~s[W], (av[W-1] ^ bv[W-1]) & (s[W-1] ^ av[W-1])});
                end
            end
        end

        wait_idle();
        repeat (3) @(negedge clk);
        probe(1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
